// File: rtl/vga_sync_gen_pkg.sv
// vga_sync_gen_pkg: 640x480@60 timing defaults, sync bundle type and window decode helper.
package vga_sync_gen_pkg;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int COLOR_W      = 12;
  localparam int CNT_W        = 10;
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } sync_t;
  // 11-bit compare so a window ending exactly at 1024 still decodes
  function automatic logic in_win(input logic [CNT_W-1:0] x, input int lo, input int len);
    return {1'b0, x} >= 11'(lo) && {1'b0, x} < 11'(lo + len);
  endfunction
endpackage

// File: rtl/vga_sync_gen_delay_line.sv
// vga_sync_gen_delay_line: DEPTH-stage shift register advancing only on ce_i.
module vga_sync_gen_delay_line #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             ce_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] sr_q [DEPTH];
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      sr_q <= '{default: '0};
    end else if (ce_i) begin
      sr_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
    end
  end
  assign q_o = sr_q[DEPTH-1];
endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA timing generator; pixel-tick divider, h/v counters, sync decode and
// latency-matched colour/sync output registers feeding the board pins.
module vga_sync_gen
  import vga_sync_gen_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter int   CLK_DIV  = 2,
  parameter int   PIX_LAT  = 2,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic               clk,
  input  logic               clrn,
  output logic [CNT_W-1:0]   col,
  output logic [CNT_W-1:0]   row,
  output logic               req,
  input  logic [COLOR_W-1:0] rgb_in,
  output logic               frame_start,
  output logic               hs,
  output logic               vs,
  output logic [3:0]         r,
  output logic [3:0]         g,
  output logic [3:0]         b
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [CNT_W-1:0]   h_q, h_d, v_q, v_d;
  logic [COLOR_W-1:0] rgb_q, rgb_d;
  logic               hs_q, hs_d, vs_q, vs_d, fs_q, fs_d, run_q;
  logic               pix_ce, h_wrap, v_wrap, active;
  sync_t              raw, tap;
  always_comb begin
    pix_ce = div_q == DIV_W'(CLK_DIV - 1);
    div_d  = pix_ce ? '0 : div_q + DIV_W'(1);
    h_wrap = h_q == CNT_W'(H_TOTAL - 1);
    v_wrap = v_q == CNT_W'(V_TOTAL - 1);
    h_d    = !pix_ce ? h_q : h_wrap ? '0 : h_q + CNT_W'(1);
    v_d    = !(pix_ce && h_wrap) ? v_q : v_wrap ? '0 : v_q + CNT_W'(1);
    active = h_q < CNT_W'(H_ACTIVE) && v_q < CNT_W'(V_ACTIVE);
    raw.hs = in_win(h_q, H_ACTIVE + H_FP, H_SYNC);
    raw.vs = in_win(v_q, V_ACTIVE + V_FP, V_SYNC);
    raw.de = active;
    hs_d   = pix_ce ? (tap.hs ? SYNC_POL : ~SYNC_POL) : hs_q;
    vs_d   = pix_ce ? (tap.vs ? SYNC_POL : ~SYNC_POL) : vs_q;
    rgb_d  = pix_ce ? (tap.de ? rgb_in : '0) : rgb_q;
    fs_d   = pix_ce && h_wrap && v_wrap;
  end
  // tap holds the sync/de of the tick whose colour the renderer is returning now
  vga_sync_gen_delay_line #(
    .WIDTH($bits(sync_t)),
    .DEPTH(PIX_LAT)
  ) u_delay (
    .clk (clk),
    .clrn(clrn),
    .ce_i(pix_ce),
    .d_i (raw),
    .q_o (tap)
  );
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
      hs_q  <= ~SYNC_POL;
      vs_q  <= ~SYNC_POL;
      rgb_q <= '0;
      fs_q  <= 1'b0;
      run_q <= 1'b0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      rgb_q <= rgb_d;
      fs_q  <= fs_d;
      run_q <= 1'b1;
    end
  end
  assign col         = h_q;
  assign row         = v_q;
  assign req         = active && run_q;
  assign frame_start = fs_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign {r, g, b}   = rgb_q;
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: scoreboard bench; full 800-pixel lines, shortened 9-line frame.
module tb_vga_sync_gen;
  localparam int HA = 640, HF = 16, HS = 96, HB = 48, HT = HA + HF + HS + HB;
  localparam int VA = 4, VF = 1, VS = 2, VB = 2, VT = VA + VF + VS + VB;
  localparam int DIV = 2, LAT = 2;
  localparam int FRAME_CLK = VT * HT * DIV;
  typedef struct packed {
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } out_t;
  logic        clk = 1'b0;
  logic        clrn = 1'b1;
  logic        stuck = 1'b0;
  logic [11:0] rgb_in, rp0, rp1;
  logic [9:0]  col, row;
  logic        req, frame_start, hs, vs, mon_ce, fs_exp, found;
  logic [3:0]  r, g, b;
  out_t        exp_q[$];
  out_t        ev, got;
  int          tdiv, th, tv, cyc;
  int          checks = 0, errors = 0;
  int          hs_fall, vs_fall, fs_t;
  logic        hs_prev, vs_prev;

  vga_sync_gen #(
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .CLK_DIV(DIV), .PIX_LAT(LAT)
  ) dut (
    .clk(clk), .clrn(clrn), .col(col), .row(row), .req(req), .rgb_in(rgb_in),
    .frame_start(frame_start), .hs(hs), .vs(vs), .r(r), .g(g), .b(b)
  );

  always #10 clk = ~clk;
  assign rgb_in = stuck ? 12'hFFF : rp1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
    end
  endtask

  // Stimulus side: reference counters, renderer model, expected-output pushes.
  always @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      tdiv <= 0; th <= 0; tv <= 0; cyc <= 0;
      mon_ce <= 1'b0; fs_exp <= 1'b0; rp0 <= '0; rp1 <= '0;
    end else begin
      cyc    <= cyc + 1;
      mon_ce <= tdiv == DIV - 1;
      fs_exp <= tdiv == DIV - 1 && th == HT - 1 && tv == VT - 1;
      if (tdiv == DIV - 1) begin
        ev.hs  = !(th >= HA + HF && th < HA + HF + HS);
        ev.vs  = !(tv >= VA + VF && tv < VA + VF + VS);
        ev.rgb = (th < HA && tv < VA) ? (stuck ? 12'hFFF : {4'(th), 4'(tv), 4'hA}) : 12'h000;
        exp_q.push_back(ev);
        tdiv <= 0;
        th   <= th == HT - 1 ? 0 : th + 1;
        tv   <= th == HT - 1 ? (tv == VT - 1 ? 0 : tv + 1) : tv;
        rp1  <= rp0;
        rp0  <= {col[3:0], row[3:0], 4'hA};
      end else begin
        tdiv <= tdiv + 1;
      end
    end
  end

  // Monitor: pops one expected word per pixel tick and checks timing intervals.
  always @(negedge clk) begin
    if (!clrn) begin
      chk("rst_hs", hs, 1); chk("rst_vs", vs, 1); chk("rst_rgb", {r, g, b}, 0);
      chk("rst_req", req, 0); chk("rst_fs", frame_start, 0);
      chk("rst_col", col, 0); chk("rst_row", row, 0);
    end else begin
      chk("col", col, th);
      chk("row", row, tv);
      chk("req", req, th < HA && tv < VA && cyc != 0);
      chk("frame_start", frame_start, fs_exp);
      if (mon_ce) begin
        if (exp_q.size() == 0) chk("sb_empty", 1, 0);
        else begin
          got = exp_q.pop_front();
          chk("pin_hs", hs, got.hs);
          chk("pin_vs", vs, got.vs);
          chk("pin_rgb", {r, g, b}, got.rgb);
        end
      end
      if (hs_prev && !hs) begin
        if (hs_fall < 0) chk("hs_first_fall", cyc, (HA + HF + LAT + 1) * DIV);
        else chk("hs_period", cyc - hs_fall, HT * DIV);
        hs_fall = cyc;
      end
      if (!hs_prev && hs && hs_fall >= 0) chk("hs_width", cyc - hs_fall, HS * DIV);
      if (vs_prev && !vs) begin
        if (vs_fall < 0) chk("vs_first_fall", cyc, (VA + VF) * HT * DIV + (LAT + 1) * DIV);
        else chk("vs_period", cyc - vs_fall, FRAME_CLK);
        vs_fall = cyc;
      end
      if (!vs_prev && vs && vs_fall >= 0) chk("vs_width", cyc - vs_fall, VS * HT * DIV);
      if (frame_start) begin
        chk(fs_t < 0 ? "fs_first" : "fs_period", fs_t < 0 ? cyc : cyc - fs_t, FRAME_CLK);
        fs_t = cyc;
      end
      hs_prev = hs;
      vs_prev = vs;
    end
  end

  task automatic do_reset(input int hold_ns, input logic stk);
    clrn  = 1'b0;
    stuck = stk;
    exp_q.delete();
    repeat (LAT) exp_q.push_back({1'b1, 1'b1, 12'h000});
    hs_prev = 1'b1; vs_prev = 1'b1; hs_fall = -1; vs_fall = -1; fs_t = -1;
    #1;
    chk("rst_now_hs", hs, 1); chk("rst_now_vs", vs, 1);
    chk("rst_now_rgb", {r, g, b}, 0); chk("rst_now_req", req, 0);
    #(hold_ns);
    @(posedge clk);
    #5 clrn = 1'b1;
  endtask

  initial begin
    #1 do_reset(200, 1'b0);
    repeat (2 * FRAME_CLK + 100) @(negedge clk);
    found = 1'b0;
    for (int i = 0; i < 10000 && !found; i++) begin
      @(negedge clk);
      found = col == 10'd300 && row == 10'd2;
    end
    chk("midline_reach", found, 1);
    #3 do_reset(10, 1'b0);
    repeat (2 * HT * DIV) @(negedge clk);
    #3 do_reset(50, 1'b1);
    repeat (FRAME_CLK + 200) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
